// File: rtl/uart_pkg.sv
// Shared constants for the UART-side blocks: byte width, launch FSM encoding
// and the default completion timeout.
package uart_pkg;

    localparam int BYTE_W             = 8;
    localparam int DEFAULT_TX_TIMEOUT = 200000;

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_WAIT = 1'b1;

    typedef enum logic {
        S_IDLE = ST_IDLE,
        S_WAIT = ST_WAIT
    } tx_state_e;

    typedef logic [BYTE_W-1:0] byte_t;

endpackage

// File: rtl/sync_fifo_mem.sv
// DEPTH x BYTE_W circular buffer with wrapping pointers and a separate
// occupancy register; full/empty derive only from that register.
module sync_fifo_mem
    import uart_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [BYTE_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [BYTE_W-1:0] rd_data,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              drop
);

    logic [BYTE_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              push;
    logic              pop;

    assign full    = (count == (ADDR_W+1)'(DEPTH));
    assign empty   = (count == '0);
    assign push    = wr_en && !full;
    assign pop     = rd_en && !empty;
    // A write into a full FIFO is dropped even if a pop frees a slot this cycle.
    assign drop    = wr_en && full;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (ADDR_W+1)'(1);
                2'b01:   count <= count - (ADDR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Transmit buffer feeding the UART: queues bytes, launches one at a time on
// tx_wr and waits for tx_done, with a watchdog for lost completions.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int ADDR_W  = 4,
    parameter int TIMEOUT = DEFAULT_TX_TIMEOUT
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic [BYTE_W-1:0] wr_data,
    input  logic              wr_en,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              ovf,
    output logic              tx_err,
    input  logic              err_clr,
    output logic              busy,
    output logic [BYTE_W-1:0] tx_data,
    output logic              tx_wr,
    input  logic              tx_done,
    output tx_state_e         dbg_state
);

    localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    tx_state_e         state_q;
    tx_state_e         state_d;
    logic [WD_W-1:0]   wd_q;
    logic [WD_W-1:0]   wd_d;
    logic              launch;
    logic              err_set;
    logic              drop;
    logic [BYTE_W-1:0] head_data;
    logic [BYTE_W-1:0] tx_data_q;
    logic              tx_wr_q;
    logic              ovf_q;
    logic              tx_err_q;

    sync_fifo_mem #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk     (sys_clk),
        .rst_n   (sys_rst_n),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .rd_en   (launch),
        .rd_data (head_data),
        .full    (full),
        .empty   (empty),
        .count   (count),
        .drop    (drop)
    );

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= S_IDLE;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            wd_q    <= wd_d;
        end
    end

    // tx_done is only meaningful in WAIT, including the cycle tx_wr is high.
    always_comb begin
        state_d = state_q;
        wd_d    = wd_q;
        launch  = 1'b0;
        err_set = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    launch  = 1'b1;
                    wd_d    = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                wd_d = wd_q + WD_W'(1);
                if (tx_done) begin
                    state_d = S_IDLE;
                end else if ((TIMEOUT != 0) && (wd_q == WD_LAST)) begin
                    err_set = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            tx_data_q <= '0;
            tx_wr_q   <= 1'b0;
            ovf_q     <= 1'b0;
            tx_err_q  <= 1'b0;
        end else begin
            tx_wr_q <= launch;
            if (launch) begin
                tx_data_q <= head_data;
            end
            // Set events take priority over a coincident clear.
            if (drop) begin
                ovf_q <= 1'b1;
            end else if (err_clr) begin
                ovf_q <= 1'b0;
            end
            if (err_set) begin
                tx_err_q <= 1'b1;
            end else if (err_clr) begin
                tx_err_q <= 1'b0;
            end
        end
    end

    assign tx_data   = tx_data_q;
    assign tx_wr     = tx_wr_q;
    assign ovf       = ovf_q;
    assign tx_err    = tx_err_q;
    assign busy      = (state_q == S_WAIT);
    assign dbg_state = state_q;

endmodule
